// File: rtl/check_dispatcher.sv
// Dispatches target-hash loads and candidate checks to a single hash checker.
// Candidates queue in a small FIFO; loads take priority and share the request bus.
module check_dispatcher #(
   parameter int FIFO_DEPTH = 4,
   parameter int MAX_HASHES = 128,
   parameter int TIMEOUT    = 64
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load_valid,
   input  logic [127:0] load_hash,
   output logic         load_ready,
   input  logic         cand_valid,
   input  logic [127:0] cand_hash,
   input  logic [31:0]  cand_tag,
   output logic         cand_ready,
   output logic         newrdy,
   output logic         checkrdy,
   output logic [127:0] hash,
   input  logic         resultrdy,
   input  logic         matchfound,
   output logic         match_valid,
   output logic [31:0]  match_tag,
   output logic [7:0]   loaded_count,
   output logic [31:0]  checked_count,
   output logic         timeout_err
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
   localparam logic [7:0]    MAX_C   = 8'(MAX_HASHES);
   localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD_PULSE,
      CHECK_PULSE,
      WAIT,
      REPORT
   } state_t;

   state_t          state;
   logic [159:0]    mem [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   logic            load_pend;
   logic [127:0]    load_reg;
   logic            is_load;
   logic [31:0]     cur_tag;
   logic [TW-1:0]   wait_cnt;
   logic            push;
   logic            pop;
   logic            load_fire;

   assign cand_ready = (count < DEPTH_C);
   assign load_ready = !load_pend && (loaded_count < MAX_C);
   assign push       = cand_valid && cand_ready;
   assign load_fire  = load_valid && load_ready;
   // Pending load blocks the pop so loads always win arbitration.
   assign pop        = (state == IDLE) && !load_pend && (count != '0);

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= {cand_tag, cand_hash};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PW'(1);
         if (pop)
            rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         load_pend     <= 1'b0;
         load_reg      <= '0;
         is_load       <= 1'b0;
         cur_tag       <= '0;
         wait_cnt      <= '0;
         newrdy        <= 1'b0;
         checkrdy      <= 1'b0;
         hash          <= '0;
         match_valid   <= 1'b0;
         match_tag     <= '0;
         loaded_count  <= '0;
         checked_count <= '0;
         timeout_err   <= 1'b0;
      end else begin
         if (load_fire) begin
            load_pend <= 1'b1;
            load_reg  <= load_hash;
         end
         case (state)
            IDLE: begin
               if (load_pend) begin
                  newrdy  <= 1'b1;
                  hash    <= load_reg;
                  is_load <= 1'b1;
                  state   <= LOAD_PULSE;
               end else if (pop) begin
                  checkrdy        <= 1'b1;
                  {cur_tag, hash} <= mem[rd_ptr];
                  is_load         <= 1'b0;
                  state           <= CHECK_PULSE;
               end
            end
            LOAD_PULSE: begin
               newrdy   <= 1'b0;
               wait_cnt <= '0;
               state    <= WAIT;
            end
            CHECK_PULSE: begin
               checkrdy <= 1'b0;
               wait_cnt <= '0;
               state    <= WAIT;
            end
            WAIT: begin
               if (resultrdy) begin
                  if (is_load) begin
                     loaded_count <= loaded_count + 8'd1;
                     load_pend    <= 1'b0;
                     state        <= IDLE;
                  end else begin
                     checked_count <= checked_count + 32'd1;
                     match_valid   <= matchfound;
                     if (matchfound)
                        match_tag <= cur_tag;
                     state <= REPORT;
                  end
               end else if (wait_cnt == T_LAST) begin
                  // Silent checker: flag it and drop the request.
                  timeout_err <= 1'b1;
                  if (is_load)
                     load_pend <= 1'b0;
                  state <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt + TW'(1);
               end
            end
            REPORT: begin
               match_valid <= 1'b0;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_check_dispatcher.sv
// Directed bench for check_dispatcher with a simple delayed-response
// checker model and a negedge request monitor.
module tb_check_dispatcher;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         load_valid = 1'b0;
   logic [127:0] load_hash = '0;
   logic         load_ready;
   logic         cand_valid = 1'b0;
   logic [127:0] cand_hash = '0;
   logic [31:0]  cand_tag = '0;
   logic         cand_ready;
   logic         newrdy;
   logic         checkrdy;
   logic [127:0] hash;
   logic         resultrdy = 1'b0;
   logic         matchfound = 1'b0;
   logic         match_valid;
   logic [31:0]  match_tag;
   logic [7:0]   loaded_count;
   logic [31:0]  checked_count;
   logic         timeout_err;

   check_dispatcher dut (
      .clk          (clk),
      .reset        (reset),
      .load_valid   (load_valid),
      .load_hash    (load_hash),
      .load_ready   (load_ready),
      .cand_valid   (cand_valid),
      .cand_hash    (cand_hash),
      .cand_tag     (cand_tag),
      .cand_ready   (cand_ready),
      .newrdy       (newrdy),
      .checkrdy     (checkrdy),
      .hash         (hash),
      .resultrdy    (resultrdy),
      .matchfound   (matchfound),
      .match_valid  (match_valid),
      .match_tag    (match_tag),
      .loaded_count (loaded_count),
      .checked_count(checked_count),
      .timeout_err  (timeout_err)
   );

   always #5 clk = ~clk;

   int nvec = 0;
   int nerr = 0;

   int rsp_delay = 4;
   bit rsp_en    = 1'b1;
   bit rsp_match = 1'b0;
   int rsp_cnt   = 0;

   int           n_new = 0;
   int           n_mv = 0;
   int           simul = 0;
   int           ev[$];
   logic [31:0]  tags[$];
   logic [127:0] last_new_hash = '0;

   localparam logic [127:0] AA = {16{8'hAA}};

   // Checker model: one-cycle resultrdy rsp_delay negedges after a pulse.
   always @(negedge clk) begin
      if (reset) begin
         rsp_cnt   = 0;
         resultrdy = 1'b0;
      end else begin
         resultrdy = 1'b0;
         if (rsp_cnt == 1) begin
            resultrdy  = 1'b1;
            matchfound = rsp_match;
            rsp_cnt    = 0;
         end else if (rsp_cnt > 1) begin
            rsp_cnt = rsp_cnt - 1;
         end
         if ((newrdy || checkrdy) && rsp_en)
            rsp_cnt = rsp_delay;
      end
   end

   always @(negedge clk) begin
      if (newrdy) begin
         n_new++;
         ev.push_back(0);
         last_new_hash = hash;
      end
      if (checkrdy) begin
         ev.push_back(1);
         tags.push_back(hash[31:0]);
      end
      if (newrdy && checkrdy)
         simul++;
      if (match_valid)
         n_mv++;
   end

   task automatic chk(input string tag, input logic [127:0] obs,
                      input logic [127:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_cand(input logic [31:0] tag);
      int n = 0;
      @(negedge clk);
      cand_valid = 1'b1;
      cand_tag   = tag;
      cand_hash  = {4{tag}};
      while (!cand_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("cand_accept", cand_ready, 1);
      @(posedge clk);
   endtask

   task automatic send_load(input logic [127:0] h);
      int n = 0;
      @(negedge clk);
      load_valid = 1'b1;
      load_hash  = h;
      while (!load_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("load_accept", load_ready, 1);
      @(posedge clk);
   endtask

   task automatic wait_checked(input int v);
      int n = 0;
      while (checked_count != v && n < 1000) begin
         @(negedge clk);
         n++;
      end
      #1;
      chk("checked_count", checked_count, v);
   endtask

   task automatic chk_zero(input string p);
      chk({p, "_newrdy"}, newrdy, 0);
      chk({p, "_checkrdy"}, checkrdy, 0);
      chk({p, "_hash"}, hash, 0);
      chk({p, "_match_valid"}, match_valid, 0);
      chk({p, "_match_tag"}, match_tag, 0);
      chk({p, "_loaded"}, loaded_count, 0);
      chk({p, "_checked"}, checked_count, 0);
      chk({p, "_timeout"}, timeout_err, 0);
      chk({p, "_cand_ready"}, cand_ready, 1);
      chk({p, "_load_ready"}, load_ready, 1);
   endtask

   initial begin
      int n;
      int snap;

      repeat (3) @(negedge clk);
      #1;
      chk_zero("rst");

      // Load on the very first edge after reset release.
      @(negedge clk);
      reset      = 1'b0;
      load_valid = 1'b1;
      load_hash  = AA;
      chk("first_load_ready", load_ready, 1);
      @(posedge clk);
      @(negedge clk);
      load_valid = 1'b0;
      chk("load_lat0", newrdy, 0);
      @(negedge clk);
      chk("load_pulse", newrdy, 1);
      chk("load_hash_out", hash, AA);
      n = 0;
      while (loaded_count != 1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      #1;
      chk("loaded_1", loaded_count, 1);
      chk("load_ready_back", load_ready, 1);
      chk("n_newrdy_1", n_new, 1);
      chk("new_hash_mon", last_new_hash, AA);

      // Match and non-match reports.
      rsp_delay = 2;
      rsp_match = 1'b1;
      send_cand(32'h1234);
      @(negedge clk);
      cand_valid = 1'b0;
      chk("check_lat0", checkrdy, 0);
      @(negedge clk);
      chk("check_pulse", checkrdy, 1);
      chk("check_hash", hash, {4{32'h1234}});
      wait_checked(1);
      repeat (3) @(negedge clk);
      #1;
      chk("mv_count_1", n_mv, 1);
      chk("match_tag_1234", match_tag, 32'h1234);
      rsp_match = 1'b0;
      send_cand(32'h5678);
      @(negedge clk);
      cand_valid = 1'b0;
      wait_checked(2);
      repeat (3) @(negedge clk);
      #1;
      chk("mv_count_nomatch", n_mv, 1);
      chk("match_tag_hold", match_tag, 32'h1234);

      // Six candidates against a slow checker.
      tags.delete();
      rsp_delay = 20;
      for (int i = 1; i <= 5; i++)
         send_cand(i);
      @(negedge clk);
      chk("fifo_full", cand_ready, 0);
      send_cand(6);
      @(negedge clk);
      cand_valid = 1'b0;
      wait_checked(8);
      chk("order_size", tags.size(), 6);
      for (int i = 0; i < 6; i++)
         chk($sformatf("order_%0d", i), tags[i], i + 1);

      // Load and candidate offered together.
      rsp_delay = 2;
      ev.delete();
      @(negedge clk);
      load_valid = 1'b1;
      load_hash  = {8{16'h5A5A}};
      cand_valid = 1'b1;
      cand_tag   = 32'h55;
      cand_hash  = {4{32'h55}};
      chk("both_ready", {load_ready, cand_ready}, 2'b11);
      @(posedge clk);
      @(negedge clk);
      load_valid = 1'b0;
      cand_valid = 1'b0;
      wait_checked(9);
      chk("loaded_2", loaded_count, 2);
      chk("ev_size", ev.size(), 2);
      chk("ev_first_load", ev[0], 0);
      chk("ev_second_check", ev[1], 1);

      // Silent checker: timeout then next entry.
      rsp_en    = 1'b0;
      rsp_match = 1'b0;
      repeat (2) @(negedge clk);
      send_cand(32'h77);
      send_cand(32'h88);
      @(negedge clk);
      cand_valid = 1'b0;
      n = 1;
      while (!timeout_err && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("timeout_cycles", n, 66);
      chk("timeout_err", timeout_err, 1);
      chk("timeout_nocount", checked_count, 9);
      rsp_en    = 1'b1;
      rsp_delay = 2;
      @(negedge clk);
      chk("after_to_pulse", checkrdy, 1);
      chk("after_to_hash", hash[31:0], 32'h88);
      wait_checked(10);
      chk("timeout_sticky", timeout_err, 1);

      // Fill the target table.
      rsp_delay = 1;
      for (int i = 0; i < 126; i++)
         send_load(128'(i));
      @(negedge clk);
      load_valid = 1'b0;
      n = 0;
      while (loaded_count != 128 && n < 100) begin
         @(negedge clk);
         n++;
      end
      #1;
      chk("loaded_128", loaded_count, 128);
      chk("load_ready_sat", load_ready, 0);
      snap = n_new;
      load_valid = 1'b1;
      load_hash  = AA;
      repeat (10) @(negedge clk);
      #1;
      chk("load_stall_ready", load_ready, 0);
      chk("load_stall_pulses", n_new, snap);
      chk("loaded_still_128", loaded_count, 128);
      load_valid = 1'b0;

      // Reset in the middle of WAIT.
      rsp_en = 1'b0;
      send_cand(32'h99);
      send_cand(32'hAB);
      @(negedge clk);
      cand_valid = 1'b0;
      repeat (3) @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk_zero("midrst");
      @(negedge clk);
      reset  = 1'b0;
      rsp_en = 1'b1;
      #1;
      snap = ev.size();
      n    = n_mv;
      repeat (20) @(negedge clk);
      #1;
      chk("post_rst_no_req", ev.size(), snap);
      chk("post_rst_checked", checked_count, 0);
      chk("post_rst_no_mv", n_mv, n);
      chk("post_rst_fifo", cand_ready, 1);

      chk("never_simul", simul, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
